seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu_pkg.sv | 24 ++
 rtl/seq_alu_mul.sv | 57 +++++
 rtl/seq_alu.sv | 127 ++++++++++++
 tb/tb_seq_alu.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared definitions for seq_alu: op-code width, op-code constants and the
// control FSM state encoding.
package seq_alu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b0001;
  localparam logic [OP_W-1:0] OP_AND  = 4'b0010;
  localparam logic [OP_W-1:0] OP_OR   = 4'b0011;
  localparam logic [OP_W-1:0] OP_SLTU = 4'b0100;
  localparam logic [OP_W-1:0] OP_SLL  = 4'b0101;
  localparam logic [OP_W-1:0] OP_SRL  = 4'b0110;
  localparam logic [OP_W-1:0] OP_SRA  = 4'b0111;
  localparam logic [OP_W-1:0] OP_SLT  = 4'b1000;
  localparam logic [OP_W-1:0] OP_MUL  = 4'b1001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles,
// product is the low WIDTH bits. done pulses during the final iteration.
module seq_alu_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (start) begin
      a_d   = a;
      b_d   = b;
      acc_d = '0;
      cnt_d = CNT_W'(WIDTH);
    end else if (cnt_q != '0) begin
      acc_d = acc_q + (b_q[0] ? a_q : '0);
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Result is taken from the next-state accumulator so the product is ready
  // in the same cycle as the last iteration.
  assign done    = (cnt_q == CNT_W'(1));
  assign product = acc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes. Single-cycle ops complete in one
// cycle; MUL is iterative and only present when SEQ_ALU_MUL_EN is defined.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam int SH_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d, alu_res, mul_product;
  logic             zero_q, zero_d, illegal_q, illegal_d, alu_ill;
  logic             is_mul, mul_done;
  logic [SH_W-1:0]  shamt;

  assign shamt = src_b[SH_W-1:0];

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    unique case (op)
      OP_ADD:  alu_res = src_a + src_b;
      OP_SUB:  alu_res = src_a - src_b;
      OP_AND:  alu_res = src_a & src_b;
      OP_OR:   alu_res = src_a | src_b;
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
      OP_SLL:  alu_res = src_a << shamt;
      OP_SRL:  alu_res = src_a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(src_a) >>> shamt);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_ill = 1'b1;
    endcase
  end

`ifdef SEQ_ALU_MUL_EN
  logic mul_start;

  assign is_mul    = (op == OP_MUL);
  assign mul_start = (state_q == IDLE) && in_valid && is_mul;

  seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (src_a),
    .b       (src_b),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign is_mul      = 1'b0;
  assign mul_done    = 1'b0;
  assign mul_product = '0;
`endif

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (is_mul) begin
            state_d = BUSY;
          end else begin
            result_d  = alu_res;
            zero_d    = (alu_res == '0);
            illegal_d = alu_ill;
            state_d   = DONE;
          end
        end
      end
      BUSY: begin
        if (mul_done) begin
          result_d  = mul_product;
          zero_d    = (mul_product == '0);
          illegal_d = 1'b0;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed corner cases plus randomized ops
// compared against an arithmetic reference model.
module tb_seq_alu;

`ifdef SEQ_ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = '0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int checks = 0;
  int failures = 0;

  seq_alu #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: returns {illegal, result} straight from the op definitions.
  function automatic logic [32:0] ref_alu(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    int sh;
    logic signed [31:0] sa;
    sh = int'(b % 32);
    sa = a;
    case (o)
      4'd0: return {1'b0, a + b};
      4'd1: return {1'b0, a - b};
      4'd2: return {1'b0, a & b};
      4'd3: return {1'b0, a | b};
      4'd4: return {1'b0, (a < b) ? 32'd1 : 32'd0};
      4'd5: return {1'b0, a << sh};
      4'd6: return {1'b0, a >> sh};
      4'd7: return {1'b0, 32'(sa >>> sh)};
      4'd8: return {1'b0, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0};
      4'd9: begin
        if (MUL_EN) return {1'b0, 32'(64'(a) * 64'(b))};
        return {1'b1, 32'd0};
      end
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  // Issue one request, measure latency, optionally stall the consumer for
  // `hold` cycles, then accept the result.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    logic [32:0] exp;
    int exp_lat, lat, busy_cnt, n;
    exp = ref_alu(o, a, b);
    exp_lat = (MUL_EN && o == 4'd9) ? 33 : 1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready_wait"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    op = o;
    src_a = a;
    src_b = b;
    out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    busy_cnt = 0;
    while (!out_valid && lat < 100) begin
      if (!in_ready) busy_cnt++;
      src_a = $urandom;
      src_b = $urandom;
      op = 4'($urandom);
      in_valid = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat - 1));
    check({tag, "_result"}, 64'(result), 64'(exp[31:0]));
    check({tag, "_zero"}, 64'(zero), 64'(exp[31:0] == 32'd0));
    check({tag, "_illegal"}, 64'(illegal), 64'(exp[32]));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      op = 4'($urandom);
      src_a = $urandom;
      src_b = $urandom;
      @(negedge clk);
      check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_hold_result"}, {31'd0, illegal, result}, 64'(exp));
      check({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_idle_after"}, {62'd0, in_ready, out_valid}, 64'b10);
    out_ready = 1'b0;
  endtask

  initial begin
    int quiet;
    // Asynchronous reset state, sampled while reset is asserted.
    #2;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_outputs", {61'd0, zero, illegal, |result}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", 64'(in_ready), 64'd1);

    run_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("slt", 4'd8, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("sltu", 4'd4, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("sra36", 4'd7, 32'h8000_0000, 32'd36, 0);
    run_op("mul", 4'd9, 32'h0001_0003, 32'h0000_0005, 0);
    run_op("illegal_f", 4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    run_op("hold10", 4'd1, 32'd100, 32'd42, 10);

    // Reset in the middle of an operation: the request must vanish.
    while (!in_ready) @(negedge clk);
    in_valid = 1'b1;
    op = 4'd9;
    src_a = 32'h0001_0003;
    src_b = 32'h0000_0005;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 1; i < 12; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    check("midreset_in_ready", 64'(in_ready), 64'd1);
    check("midreset_result", 64'(result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset_ready_after", 64'(in_ready), 64'd1);
    quiet = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) quiet++;
    end
    check("midreset_no_result", 64'(quiet), 64'd0);
    out_ready = 1'b0;
    run_op("add_after_reset", 4'd0, 32'd2, 32'd3, 0);

    for (int i = 0; i < 40; i++) begin
      run_op("rand", 4'($urandom_range(0, 15)), $urandom, $urandom, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
